flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumer end of the flag interface. Samples the registered Carry/Zero/Borrow flags and resolves conditional and unconditional jumps, CALL and RET.
- Owns the program counter and a small return-address stack.
- Issues a one-cycle flush bubble after every taken control transfer.
- Sits between the instruction decoder and instruction memory addressing.

Parameters:
- ADDR_W, 8, program counter and target address width.
- STACK_DEPTH, 4, number of return-address entries (power of two not required).
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- EN  input  1  advance enable; low freezes all state.
- BR_VALID  input  1  OP/TARGET valid this cycle.
- OP  input  3  000 NOP, 001 JMP, 010 JC, 011 JZ, 100 JB, 101 JNZ, 110 CALL, 111 RET.
- TARGET  input  ADDR_W  jump/call destination.
- FLAG_C  input  1  carry flag from flag register.
- FLAG_Z  input  1  zero flag from flag register.
- FLAG_B  input  1  borrow flag from flag register.
- PC  output  ADDR_W  current program counter, registered.
- TAKEN  output  1  registered pulse: transfer taken last edge.
- FLUSH  output  1  high during bubble cycle; fetched instruction must be discarded.
- BUSY  output  1  high in BUBBLE or ERR; BR_VALID ignored.
- STACK_ERR  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (RST=0, async): PC=RESET_VEC, SP=0, state=RUN. TAKEN, FLUSH, BUSY and STACK_ERR are all 0. Stack contents are don't-care.
- FSM has three states: RUN, BUBBLE, ERR.
- RUN, EN=1, BR_VALID=0 or OP=NOP: PC<=PC+1, modulo 2^ADDR_W, so max wraps to 0.
- RUN, EN=1, BR_VALID=1: condition evaluated from the flags in the same cycle (combinational sample).
  - JMP: always taken.
  - JC: taken if FLAG_C=1.
  - JZ: taken if FLAG_Z=1.
  - JB: taken if FLAG_B=1.
  - JNZ: taken if FLAG_Z=0.
  - CALL: always taken; pushes PC+1 (wrapped) to stack[SP], SP<=SP+1.
  - RET: always taken; PC<=stack[SP-1], SP<=SP-1.
- Taken: PC<=TARGET (or the popped address for RET), TAKEN<=1, FLUSH<=1, BUSY<=1, next state BUBBLE.
- Not taken: PC<=PC+1, stay in RUN.
- BUBBLE: lasts exactly one enabled cycle; PC holds. BR_VALID is ignored and no push/pop occurs. Then TAKEN, FLUSH and BUSY return to 0 and state returns to RUN.
- Taken-branch latency: new PC visible 1 cycle after BR_VALID. The first usable fetch is the cycle after that.
- CALL with SP=STACK_DEPTH (full): no push, PC unchanged, STACK_ERR<=1, BUSY<=1, state ERR.
- RET with SP=0 (empty): no pop, PC unchanged, STACK_ERR<=1, BUSY<=1, state ERR.
- ERR: PC, SP and stack are frozen and all inputs are ignored. Exit only via RST.
- EN=0 in any state: all registers hold, including TAKEN, FLUSH and BUSY. A BUBBLE is extended until an EN=1 cycle consumes it.
- Flag inputs are never registered here. Changes while BR_VALID=0 have no effect.
- Unused OP encodings: none; all 8 are defined.
- RST asserted mid-BUBBLE or in ERR: immediate return to reset values regardless of CLK.

Test Plan:
- Reset then 5 enabled NOP cycles, RESET_VEC=0 -> PC sequence 0,1,2,3,4,5. TAKEN=FLUSH=BUSY=STACK_ERR=0 throughout.
- PC=0xFE, two NOPs -> PC 0xFF then 0x00; no error, no TAKEN.
- JC TARGET=0x40 with FLAG_C=0 -> PC=PC+1, TAKEN=0. Repeat with FLAG_C=1 -> PC=0x40 next cycle, TAKEN=FLUSH=1 for one cycle. A BR_VALID JMP 0x80 issued during the bubble is ignored and PC stays 0x40.
- JNZ 0x10 with FLAG_Z=1 -> not taken. JZ 0x10 with FLAG_Z=1 -> PC=0x10. JB 0x20 with FLAG_B=1 -> PC=0x20.
- At PC=0x05, CALL 0x30 -> PC=0x30. After bubble, NOP to 0x31, then RET -> PC=0x06.
  - 4 nested CALLs then a 5th -> STACK_ERR=1, BUSY=1, PC frozen.
  - RST low -> PC=RESET_VEC, STACK_ERR=0.
- After reset, RET -> STACK_ERR=1, ERR state. EN toggling and BR_VALID pulses leave PC unchanged until RST.

Source files
------------

// File: rtl/flag_branch_unit.sv
// Branch resolution unit: owns the PC and a small return-address stack, resolves
// flag-conditional jumps, CALL and RET, and inserts a one-cycle flush bubble after every taken transfer.
module flag_branch_unit #(
    parameter int unsigned     ADDR_W      = 8,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              BR_VALID,
    input  logic [2:0]        OP,
    input  logic [ADDR_W-1:0] TARGET,
    input  logic              FLAG_C,
    input  logic              FLAG_Z,
    input  logic              FLAG_B,
    output logic [ADDR_W-1:0] PC,
    output logic              TAKEN,
    output logic              FLUSH,
    output logic              BUSY,
    output logic              STACK_ERR
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StBubble = 2'd1;
    localparam logic [1:0] StErr    = 2'd2;

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpJmp  = 3'b001;
    localparam logic [2:0] OpJc   = 3'b010;
    localparam logic [2:0] OpJz   = 3'b011;
    localparam logic [2:0] OpJb   = 3'b100;
    localparam logic [2:0] OpJnz  = 3'b101;
    localparam logic [2:0] OpCall = 3'b110;
    localparam logic [2:0] OpRet  = 3'b111;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              taken_q, taken_d;
    logic              flush_q, flush_d;
    logic              busy_q, busy_d;
    logic              stack_err_q, stack_err_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pop_addr;
    logic [ADDR_W-1:0] dest;
    logic              take;
    logic              fault;
    logic              push;
    logic              stack_full;
    logic              stack_empty;

    assign pc_inc      = pc_q + ADDR_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // Top-of-stack read; the fallback value only matters when the stack is empty.
    always_comb begin
        pop_addr = pc_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                pop_addr = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        taken_d     = taken_q;
        flush_d     = flush_q;
        busy_d      = busy_q;
        stack_err_d = stack_err_q;
        take        = 1'b0;
        fault       = 1'b0;
        push        = 1'b0;
        dest        = TARGET;

        if (EN) begin
            case (state_q)
                StRun: begin
                    if (BR_VALID) begin
                        case (OP)
                            OpNop: take = 1'b0;
                            OpJmp: take = 1'b1;
                            OpJc:  take = FLAG_C;
                            OpJz:  take = FLAG_Z;
                            OpJb:  take = FLAG_B;
                            OpJnz: take = ~FLAG_Z;
                            OpCall: begin
                                if (stack_full) begin
                                    fault = 1'b1;
                                end else begin
                                    take = 1'b1;
                                    push = 1'b1;
                                    sp_d = sp_q + SP_W'(1);
                                end
                            end
                            OpRet: begin
                                if (stack_empty) begin
                                    fault = 1'b1;
                                end else begin
                                    take = 1'b1;
                                    dest = pop_addr;
                                    sp_d = sp_q - SP_W'(1);
                                end
                            end
                            default: take = 1'b0;
                        endcase
                    end

                    if (fault) begin
                        stack_err_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = StErr;
                    end else if (take) begin
                        pc_d    = dest;
                        taken_d = 1'b1;
                        flush_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = StBubble;
                    end else begin
                        pc_d    = pc_inc;
                        taken_d = 1'b0;
                        flush_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
                StBubble: begin
                    taken_d = 1'b0;
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StRun;
                end
                StErr: begin
                    // Frozen until reset.
                    state_d = StErr;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StRun;
            pc_q        <= RESET_VEC;
            sp_q        <= '0;
            taken_q     <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            taken_q     <= taken_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Stack storage needs no reset; entries above SP are never read.
    always_ff @(posedge CLK) begin
        if (push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) begin
                    stack_q[i] <= pc_inc;
                end
            end
        end
    end

    assign PC        = pc_q;
    assign TAKEN     = taken_q;
    assign FLUSH     = flush_q;
    assign BUSY      = busy_q;
    assign STACK_ERR = stack_err_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_flag_branch_unit;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic       BR_VALID = 1'b0;
    logic [2:0] OP = 3'd0;
    logic [7:0] TARGET = 8'd0;
    logic       FLAG_C = 1'b0;
    logic       FLAG_Z = 1'b0;
    logic       FLAG_B = 1'b0;
    logic [7:0] PC;
    logic       TAKEN, FLUSH, BUSY, STACK_ERR;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 = running, 1 = bubble, 2 = error.
    int m_pc;
    int m_stack[$];
    int m_mode;
    bit m_taken, m_flush, m_busy, m_err;

    flag_branch_unit #(
        .ADDR_W     (8),
        .STACK_DEPTH(DEPTH),
        .RESET_VEC  (8'h00)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .BR_VALID (BR_VALID),
        .OP       (OP),
        .TARGET   (TARGET),
        .FLAG_C   (FLAG_C),
        .FLAG_Z   (FLAG_Z),
        .FLAG_B   (FLAG_B),
        .PC       (PC),
        .TAKEN    (TAKEN),
        .FLUSH    (FLUSH),
        .BUSY     (BUSY),
        .STACK_ERR(STACK_ERR)
    );

    initial forever #5 CLK = ~CLK;

    function void model_reset();
        m_pc = 0;
        m_stack.delete();
        m_mode = 0;
        m_taken = 0;
        m_flush = 0;
        m_busy = 0;
        m_err = 0;
    endfunction

    function void model_step(input bit en, input bit v, input int op, input int tgt,
                             input bit c, input bit z, input bit b);
        bit jump;
        int dest;
        if (!en || m_mode == 2) return;
        if (m_mode == 1) begin
            m_taken = 0;
            m_flush = 0;
            m_busy = 0;
            m_mode = 0;
            return;
        end
        jump = 0;
        dest = tgt;
        if (v) begin
            case (op)
                1: jump = 1;
                2: jump = c;
                3: jump = z;
                4: jump = b;
                5: jump = !z;
                6: begin
                    if (m_stack.size() == DEPTH) begin
                        m_err = 1;
                        m_busy = 1;
                        m_mode = 2;
                        return;
                    end
                    m_stack.push_back((m_pc + 1) % 256);
                    jump = 1;
                end
                7: begin
                    if (m_stack.size() == 0) begin
                        m_err = 1;
                        m_busy = 1;
                        m_mode = 2;
                        return;
                    end
                    dest = m_stack.pop_back();
                    jump = 1;
                end
                default: jump = 0;
            endcase
        end
        if (jump) begin
            m_pc = dest;
            m_taken = 1;
            m_flush = 1;
            m_busy = 1;
            m_mode = 1;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endfunction

    function logic [11:0] got();
        return {PC, TAKEN, FLUSH, BUSY, STACK_ERR};
    endfunction

    function logic [11:0] want();
        return {8'(m_pc), m_taken, m_flush, m_busy, m_err};
    endfunction

    task automatic cyc(input bit en, input bit v, input logic [2:0] op, input logic [7:0] tgt,
                       input bit c, input bit z, input bit b);
        EN = en;
        BR_VALID = v;
        OP = op;
        TARGET = tgt;
        FLAG_C = c;
        FLAG_Z = z;
        FLAG_B = b;
        @(posedge CLK);
        model_step(en, v, int'(op), int'(tgt), c, z, b);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (got() !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", got(), 12'h000);
        end
        release_reset();
    endtask

    task automatic test_nop_seq();
        for (int i = 1; i <= 5; i++) begin
            cyc(1, (i % 2) == 0, 3'd0, 8'hAA, 1, 1, 1);
            checks++;
            if (got() !== {8'(i), 4'b0000}) begin
                errors++;
                $display("FAIL nop_seq[%0d]: got %h want %h", i, got(), {8'(i), 4'b0000});
            end
        end
    endtask

    task automatic test_wrap();
        cyc(1, 1, 3'd1, 8'hFE, 0, 0, 0);
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        checks++;
        if (got() !== {8'hFE, 4'b0000}) begin
            errors++;
            $display("FAIL wrap_setup: got %h want %h", got(), {8'hFE, 4'b0000});
        end
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        checks++;
        if (got() !== {8'hFF, 4'b0000}) begin
            errors++;
            $display("FAIL wrap_ff: got %h want %h", got(), {8'hFF, 4'b0000});
        end
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        checks++;
        if (got() !== {8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL wrap_00: got %h want %h", got(), {8'h00, 4'b0000});
        end
    endtask

    task automatic test_cond();
        logic [7:0] start;
        start = PC;
        cyc(1, 1, 3'd2, 8'h40, 0, 1, 1);
        checks++;
        if (got() !== {start + 8'd1, 4'b0000}) begin
            errors++;
            $display("FAIL jc_not_taken: got %h want %h", got(), {start + 8'd1, 4'b0000});
        end
        cyc(1, 1, 3'd2, 8'h40, 1, 0, 0);
        checks++;
        if (got() !== {8'h40, 4'b1110}) begin
            errors++;
            $display("FAIL jc_taken: got %h want %h", got(), {8'h40, 4'b1110});
        end
        cyc(1, 1, 3'd1, 8'h80, 1, 1, 1);
        checks++;
        if (got() !== {8'h40, 4'b0000}) begin
            errors++;
            $display("FAIL bubble_ignores_jmp: got %h want %h", got(), {8'h40, 4'b0000});
        end
        cyc(1, 1, 3'd5, 8'h10, 0, 1, 0);
        checks++;
        if (got() !== {8'h41, 4'b0000}) begin
            errors++;
            $display("FAIL jnz_not_taken: got %h want %h", got(), {8'h41, 4'b0000});
        end
        cyc(1, 1, 3'd3, 8'h10, 0, 1, 0);
        checks++;
        if (got() !== {8'h10, 4'b1110}) begin
            errors++;
            $display("FAIL jz_taken: got %h want %h", got(), {8'h10, 4'b1110});
        end
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        cyc(1, 1, 3'd4, 8'h20, 0, 0, 1);
        checks++;
        if (got() !== {8'h20, 4'b1110}) begin
            errors++;
            $display("FAIL jb_taken: got %h want %h", got(), {8'h20, 4'b1110});
        end
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_en_hold();
        cyc(1, 1, 3'd1, 8'h55, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3'd1, 8'h99, 1, 1, 1);
            checks++;
            if (got() !== {8'h55, 4'b1110}) begin
                errors++;
                $display("FAIL en_hold[%0d]: got %h want %h", i, got(), {8'h55, 4'b1110});
            end
        end
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        checks++;
        if (got() !== {8'h55, 4'b0000}) begin
            errors++;
            $display("FAIL en_bubble_end: got %h want %h", got(), {8'h55, 4'b0000});
        end
    endtask

    task automatic test_call_ret();
        cyc(1, 1, 3'd1, 8'h05, 0, 0, 0);
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        cyc(1, 1, 3'd6, 8'h30, 0, 0, 0);
        checks++;
        if (got() !== {8'h30, 4'b1110}) begin
            errors++;
            $display("FAIL call: got %h want %h", got(), {8'h30, 4'b1110});
        end
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        cyc(1, 1, 3'd0, 8'h00, 0, 0, 0);
        checks++;
        if (got() !== {8'h31, 4'b0000}) begin
            errors++;
            $display("FAIL call_nop: got %h want %h", got(), {8'h31, 4'b0000});
        end
        cyc(1, 1, 3'd7, 8'hEE, 0, 0, 0);
        checks++;
        if (got() !== {8'h06, 4'b1110}) begin
            errors++;
            $display("FAIL ret: got %h want %h", got(), {8'h06, 4'b1110});
        end
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 1, 3'd6, 8'(8'h60 + i), 0, 0, 0);
            cyc(1, 0, 3'd0, 8'h00, 0, 0, 0);
            checks++;
            if (got() !== want()) begin
                errors++;
                $display("FAIL nested_call[%0d]: got %h want %h", i, got(), want());
            end
        end
        cyc(1, 1, 3'd6, 8'h99, 0, 0, 0);
        checks++;
        if (got() !== {8'h63, 4'b0011}) begin
            errors++;
            $display("FAIL call_overflow: got %h want %h", got(), {8'h63, 4'b0011});
        end
        for (int i = 0; i < 4; i++) begin
            cyc(i % 2 == 0, 1, 3'(i + 6), 8'h77, 1, 0, 1);
        end
        checks++;
        if (got() !== {8'h63, 4'b0011}) begin
            errors++;
            $display("FAIL err_frozen: got %h want %h", got(), {8'h63, 4'b0011});
        end
        do_reset();
        checks++;
        if (got() !== 12'h000) begin
            errors++;
            $display("FAIL err_reset: got %h want %h", got(), 12'h000);
        end
        release_reset();
    endtask

    task automatic test_ret_empty();
        cyc(1, 1, 3'd7, 8'h44, 0, 0, 0);
        checks++;
        if (got() !== {8'h00, 4'b0011}) begin
            errors++;
            $display("FAIL ret_underflow: got %h want %h", got(), {8'h00, 4'b0011});
        end
        for (int i = 0; i < 6; i++) begin
            cyc(i % 2 == 1, 1, 3'd1, 8'h12, 0, 0, 0);
        end
        checks++;
        if (got() !== {8'h00, 4'b0011}) begin
            errors++;
            $display("FAIL underflow_frozen: got %h want %h", got(), {8'h00, 4'b0011});
        end
        do_reset();
        release_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ((m_mode == 2 && $urandom_range(3) == 0) || $urandom_range(63) == 0) begin
                do_reset();
                checks++;
                if (got() !== want()) begin
                    errors++;
                    $display("FAIL rand_reset[%0d]: got %h want %h", n, got(), want());
                end
                release_reset();
            end else begin
                cyc($urandom_range(7) != 0, $urandom_range(1) == 1, 3'($urandom_range(7)),
                    8'($urandom_range(255)), $urandom_range(1) == 1, $urandom_range(1) == 1,
                    $urandom_range(1) == 1);
                checks++;
                if (got() !== want()) begin
                    errors++;
                    $display("FAIL rand_step[%0d]: got %h want %h", n, got(), want());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nop_seq();
        test_wrap();
        test_cond();
        test_en_hold();
        test_call_ret();
        test_ret_empty();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
